// File: rtl/pll_reset_sequencer.sv
// PLL power-up sequencer: pulses the PLL reset, waits for a debounced lock,
// retries failed attempts, then releases the core reset; failure is sticky.
module pll_reset_sequencer #(
    parameter int RST_PULSE    = 32,
    parameter int LOCK_STABLE  = 1024,
    parameter int LOCK_TIMEOUT = 65536,
    parameter int MAX_RETRY    = 3,
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
    input  logic          refclk,
    input  logic          rst_n,
    input  logic          pll_locked,
    input  logic          force_relock,
    output logic          pll_rst,
    output logic          sys_rst,
    output logic          ready,
    output logic          fail,
    output logic [RW-1:0] retry_cnt
);

    localparam int CMAX_A = (RST_PULSE > LOCK_STABLE) ? RST_PULSE : LOCK_STABLE;
    localparam int CMAX   = (CMAX_A > LOCK_TIMEOUT) ? CMAX_A : LOCK_TIMEOUT;
    localparam int CW     = (CMAX > 1) ? $clog2(CMAX) : 1;

    localparam logic [CW-1:0] RST_LAST    = CW'(RST_PULSE - 1);
    localparam logic [CW-1:0] STABLE_LAST = CW'(LOCK_STABLE - 1);
    localparam logic [CW-1:0] TO_LAST     = CW'(LOCK_TIMEOUT - 1);
    localparam logic [RW-1:0] RETRY_MAX   = RW'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_PLL_RST,
        S_WAIT_LOCK,
        S_STABLE,
        S_RUN,
        S_FAIL
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [RW-1:0]   retry_q, retry_d;
    logic [1:0]      sync_q, sync_d;
    logic            pll_rst_q, pll_rst_d;
    logic            sys_rst_q, sys_rst_d;
    logic            ready_q, ready_d;
    logic            fail_q, fail_d;
    logic            locked_s;

    assign locked_s = sync_q[1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;
        sync_d  = {sync_q[0], pll_locked};
        unique case (state_q)
            S_PLL_RST: begin
                if (cnt_q == RST_LAST) state_d = S_WAIT_LOCK;
                else cnt_d = cnt_q + CW'(1);
            end
            S_WAIT_LOCK: begin
                // lock wins over a coincident timeout
                if (locked_s) begin
                    state_d = S_STABLE;
                end else if (cnt_q == TO_LAST) begin
                    if (retry_q < RETRY_MAX) begin
                        retry_d = retry_q + RW'(1);
                        state_d = S_PLL_RST;
                    end else begin
                        state_d = S_FAIL;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_STABLE: begin
                if (!locked_s) state_d = S_WAIT_LOCK;
                else if (cnt_q == STABLE_LAST) state_d = S_RUN;
                else cnt_d = cnt_q + CW'(1);
            end
            S_RUN: begin
                if (!locked_s || force_relock) begin
                    state_d = S_PLL_RST;
                    retry_d = '0;
                end
            end
            S_FAIL: begin
                if (force_relock) begin
                    state_d = S_PLL_RST;
                    retry_d = '0;
                end
            end
            default: begin
                state_d = S_PLL_RST;
                retry_d = '0;
            end
        endcase
        if (state_d != state_q) cnt_d = '0;
        pll_rst_d = (state_d == S_PLL_RST);
        sys_rst_d = (state_d != S_RUN);
        ready_d   = (state_d == S_RUN);
        fail_d    = (state_d == S_FAIL);
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_PLL_RST;
            cnt_q     <= '0;
            retry_q   <= '0;
            sync_q    <= '0;
            pll_rst_q <= 1'b1;
            sys_rst_q <= 1'b1;
            ready_q   <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retry_q   <= retry_d;
            sync_q    <= sync_d;
            pll_rst_q <= pll_rst_d;
            sys_rst_q <= sys_rst_d;
            ready_q   <= ready_d;
            fail_q    <= fail_d;
        end
    end

    assign pll_rst   = pll_rst_q;
    assign sys_rst   = sys_rst_q;
    assign ready     = ready_q;
    assign fail      = fail_q;
    assign retry_cnt = retry_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboard bench for pll_reset_sequencer: stimulus queues expected
// output vectors per cycle, a negedge monitor pops and compares them.
module tb_pll_reset_sequencer;

    localparam int RW = 2;

    logic          refclk = 1'b0;
    logic          rst_n = 1'b1;
    logic          pll_locked = 1'b0;
    logic          force_relock = 1'b0;
    logic          pll_rst, sys_rst, ready, fail;
    logic [RW-1:0] retry_cnt;

    int cyc;
    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        int            cyc;
        logic [5:0]    v;
        string         name;
    } exp_t;

    exp_t sb[$];

    pll_reset_sequencer #(
        .RST_PULSE   (4),
        .LOCK_STABLE (8),
        .LOCK_TIMEOUT(16),
        .MAX_RETRY   (2)
    ) dut (
        .refclk      (refclk),
        .rst_n       (rst_n),
        .pll_locked  (pll_locked),
        .force_relock(force_relock),
        .pll_rst     (pll_rst),
        .sys_rst     (sys_rst),
        .ready       (ready),
        .fail        (fail),
        .retry_cnt   (retry_cnt)
    );

    always #5 refclk = ~refclk;

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else cyc <= cyc + 1;
    end

    function automatic logic [5:0] outs();
        return {pll_rst, sys_rst, ready, fail, retry_cnt};
    endfunction

    task automatic cmp(string nm, logic [5:0] act, logic [5:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b (pll_rst,sys_rst,ready,fail,retry[1:0]) at cyc %0d",
                     nm, act, req, cyc);
        end
    endtask

    // expected vector: {pll_rst, sys_rst, ready, fail, retry}
    task automatic exp_at(int c, logic [5:0] v, string nm);
        exp_t e;
        e.cyc  = c;
        e.v    = v;
        e.name = nm;
        sb.push_back(e);
    endtask

    always @(negedge refclk) begin
        exp_t e;
        if (rst_n) begin
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                if (e.cyc < cyc) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL %s: missed at cyc %0d (now %0d)", e.name, e.cyc, cyc);
                end else begin
                    cmp(e.name, outs(), e.v);
                end
            end
        end
    end

    task automatic wait_cyc(int n);
        int k = 0;
        while (cyc != n && k < 400) begin
            @(negedge refclk);
            k++;
        end
        if (cyc != n) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_cyc: reached %0d expected %0d", cyc, n);
        end
    endtask

    // asserts rst_n mid-cycle, checks the async reset values, restarts
    task automatic start_seq(logic lk, string nm);
        @(negedge refclk);
        if (sb.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL %s_leftover: got %0d pending expected 0", nm, sb.size());
            sb.delete();
        end
        #2;
        rst_n = 1'b0;
        #1;
        cmp({nm, "_async_rst"}, outs(), 6'b110000);
        pll_locked   = lk;
        force_relock = 1'b0;
        @(negedge refclk);
        @(negedge refclk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        // A: lock from start, loss of lock in RUN, force_relock in RUN
        start_seq(1'b1, "a");
        exp_at(1,  6'b110000, "a_pulse_c1");
        exp_at(3,  6'b110000, "a_pulse_c3");
        exp_at(4,  6'b010000, "a_pll_rst_fall");
        exp_at(12, 6'b010000, "a_pre_run");
        exp_at(13, 6'b001000, "a_run");
        exp_at(17, 6'b001000, "a_run_hold");
        exp_at(18, 6'b110000, "a_loss_rst");
        exp_at(21, 6'b110000, "a_loss_pulse_end");
        exp_at(22, 6'b010000, "a_loss_fall");
        exp_at(30, 6'b010000, "a_pre_rerun");
        exp_at(31, 6'b001000, "a_rerun");
        exp_at(33, 6'b001000, "a_pre_force");
        exp_at(34, 6'b110000, "a_force_run");
        exp_at(37, 6'b110000, "a_force_pulse_end");
        exp_at(38, 6'b010000, "a_force_fall");
        exp_at(46, 6'b010000, "a_pre_run3");
        exp_at(47, 6'b001000, "a_run3");
        wait_cyc(15);
        pll_locked = 1'b0;
        wait_cyc(20);
        pll_locked = 1'b1;
        wait_cyc(33);
        force_relock = 1'b1;
        wait_cyc(34);
        force_relock = 1'b0;
        wait_cyc(48);

        // B: one-cycle lock glitch seen in STABLE at cnt=5
        start_seq(1'b1, "b");
        exp_at(4,  6'b010000, "b_fall");
        exp_at(13, 6'b010000, "b_no_early_run");
        exp_at(19, 6'b010000, "b_pre_run");
        exp_at(20, 6'b001000, "b_run");
        wait_cyc(8);
        pll_locked = 1'b0;
        wait_cyc(9);
        pll_locked = 1'b1;
        wait_cyc(21);

        // C: never locks -> retries -> FAIL; force_relock ignored/honoured
        start_seq(1'b0, "c");
        exp_at(3,  6'b110000, "c_pulse1_end");
        exp_at(4,  6'b010000, "c_fall1");
        exp_at(9,  6'b010000, "c_force_ignored");
        exp_at(19, 6'b010000, "c_gap1_end");
        exp_at(20, 6'b110001, "c_retry1");
        exp_at(23, 6'b110001, "c_pulse2_end");
        exp_at(24, 6'b010001, "c_fall2");
        exp_at(39, 6'b010001, "c_gap2_end");
        exp_at(40, 6'b110010, "c_retry2");
        exp_at(43, 6'b110010, "c_pulse3_end");
        exp_at(44, 6'b010010, "c_fall3");
        exp_at(59, 6'b010010, "c_pre_fail");
        exp_at(60, 6'b010110, "c_fail");
        exp_at(70, 6'b010110, "c_fail_sticky");
        exp_at(71, 6'b110000, "c_fail_clear");
        exp_at(74, 6'b110000, "c_new_pulse_end");
        exp_at(75, 6'b010000, "c_new_fall");
        wait_cyc(8);
        force_relock = 1'b1;
        wait_cyc(9);
        force_relock = 1'b0;
        wait_cyc(70);
        force_relock = 1'b1;
        wait_cyc(71);
        force_relock = 1'b0;
        wait_cyc(76);

        // D: async reset during STABLE and during RUN
        start_seq(1'b1, "d0");
        exp_at(4, 6'b010000, "d0_fall");
        exp_at(8, 6'b010000, "d0_stable");
        wait_cyc(8);
        start_seq(1'b1, "d_stable");
        exp_at(3,  6'b110000, "d1_pulse_end");
        exp_at(4,  6'b010000, "d1_fall");
        exp_at(13, 6'b001000, "d1_run");
        wait_cyc(15);
        start_seq(1'b1, "d_run");
        exp_at(4,  6'b010000, "d2_fall");
        exp_at(12, 6'b010000, "d2_pre_run");
        exp_at(13, 6'b001000, "d2_run");
        wait_cyc(14);

        @(negedge refclk);
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL final_drain: got %0d pending expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
